// File: rtl/dot_product_accumulator.sv
// rtl/dot_product_accumulator.sv - sums VECTOR_LEN MAC products into one result on a valid/ready output register
// Optional saturation build: define DOT_PRODUCT_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module dot_product_accumulator #(
    parameter int IN_WIDTH   = 64,
    parameter int ACC_WIDTH  = 64,
    parameter int VECTOR_LEN = 8,
    parameter int CNT_WIDTH  = $clog2(VECTOR_LEN + 1)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic signed [IN_WIDTH-1:0]  mac_in,
    input  logic                        mac_valid,
    input  logic                        clear,
    output logic signed [ACC_WIDTH-1:0] sum_out,
    output logic                        sum_overflow,
    output logic                        sum_valid,
    input  logic                        sum_ready,
    output logic                        drop_err,
    output logic [CNT_WIDTH-1:0]        beat_count
);

    localparam int MSB = ACC_WIDTH - 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(VECTOR_LEN - 1);

    logic signed [ACC_WIDTH-1:0] acc;
    logic                        acc_ovf;
    logic signed [ACC_WIDTH-1:0] ext_in;
    logic signed [ACC_WIDTH-1:0] sum_raw;
    logic signed [ACC_WIDTH-1:0] sum_next;
    logic                        beat_ovf;
    logic                        beat;
    logic                        last_beat;
    logic                        emit;

    assign ext_in   = ACC_WIDTH'(mac_in);
    assign sum_raw  = acc + ext_in;
    // Signed overflow: operands agree in sign but the sum does not.
    assign beat_ovf = (acc[MSB] == ext_in[MSB]) && (sum_raw[MSB] != acc[MSB]);

`ifdef DOT_PRODUCT_ACC_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    always_comb begin
        sum_next = sum_raw;
        if (beat_ovf) begin
            sum_next = acc[MSB] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    assign sum_next = sum_raw;
`endif

    assign beat      = mac_valid && !clear;
    assign last_beat = (beat_count == LAST_CNT);
    assign emit      = beat && last_beat;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            acc_ovf    <= 1'b0;
            beat_count <= '0;
        end else if (clear) begin
            acc        <= '0;
            acc_ovf    <= 1'b0;
            beat_count <= '0;
        end else if (beat) begin
            if (last_beat) begin
                acc        <= '0;
                acc_ovf    <= 1'b0;
                beat_count <= '0;
            end else begin
                acc        <= sum_next;
                acc_ovf    <= acc_ovf | beat_ovf;
                beat_count <= beat_count + CNT_WIDTH'(1);
            end
        end
    end

    // Upstream cannot stall, so a result arriving at a full, unaccepted output is dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sum_out      <= '0;
            sum_overflow <= 1'b0;
            sum_valid    <= 1'b0;
        end else if (emit && (!sum_valid || sum_ready)) begin
            sum_out      <= sum_next;
            sum_overflow <= acc_ovf | beat_ovf;
            sum_valid    <= 1'b1;
        end else if (sum_valid && sum_ready) begin
            sum_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_err <= 1'b0;
        end else if (clear) begin
            drop_err <= 1'b0;
        end else if (emit && sum_valid && !sum_ready) begin
            drop_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// tb/tb_dot_product_accumulator.sv - directed, table-driven and randomized checks of dot_product_accumulator
module tb_dot_product_accumulator;

`ifdef DOT_PRODUCT_ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam int A_MAX = 255;
    localparam int A_MIN = -256;

    logic clock;
    logic reset_n;

    logic signed [7:0] a_mac_in;
    logic              a_mac_valid;
    logic              a_clear;
    logic signed [8:0] a_sum_out;
    logic              a_sum_overflow;
    logic              a_sum_valid;
    logic              a_ready;
    logic              a_drop_err;
    logic [2:0]        a_beat_count;

    logic signed [7:0] b_mac_in;
    logic              b_mac_valid;
    logic              b_clear;
    logic signed [7:0] b_sum_out;
    logic              b_sum_overflow;
    logic              b_sum_valid;
    logic              b_ready;
    logic              b_drop_err;
    logic [1:0]        b_beat_count;

    dot_product_accumulator #(.IN_WIDTH(8), .ACC_WIDTH(9), .VECTOR_LEN(4)) dut_a (
        .clock(clock), .reset_n(reset_n), .mac_in(a_mac_in), .mac_valid(a_mac_valid),
        .clear(a_clear), .sum_out(a_sum_out), .sum_overflow(a_sum_overflow),
        .sum_valid(a_sum_valid), .sum_ready(a_ready), .drop_err(a_drop_err),
        .beat_count(a_beat_count)
    );

    dot_product_accumulator #(.IN_WIDTH(8), .ACC_WIDTH(8), .VECTOR_LEN(2)) dut_b (
        .clock(clock), .reset_n(reset_n), .mac_in(b_mac_in), .mac_valid(b_mac_valid),
        .clear(b_clear), .sum_out(b_sum_out), .sum_overflow(b_sum_overflow),
        .sum_valid(b_sum_valid), .sum_ready(b_ready), .drop_err(b_drop_err),
        .beat_count(b_beat_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests;
    int fails;

    bit model_on;
    int m_run;
    int m_cnt;
    bit m_ovf;
    bit m_sv;
    int m_sum;
    bit m_sovf;
    bit m_drop;

    typedef struct {
        int a;
        int b;
        int exp_sum;
        int exp_ovf;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer sums, clamped or wrapped into the 9-bit range per beat.
    task automatic model_step();
        int  t;
        bit  o;
        bit  fin;
        int  res;
        bit  rovf;
        fin  = 1'b0;
        res  = 0;
        rovf = 1'b0;
        if (a_clear) begin
            m_run  = 0;
            m_cnt  = 0;
            m_ovf  = 1'b0;
            m_drop = 1'b0;
        end else if (a_mac_valid) begin
            t = m_run + int'(a_mac_in);
            o = (t > A_MAX) || (t < A_MIN);
            if (o) begin
                if (SAT) t = (t > A_MAX) ? A_MAX : A_MIN;
                else     t = (t > A_MAX) ? t - 512 : t + 512;
            end
            if (m_cnt == 3) begin
                fin   = 1'b1;
                res   = t;
                rovf  = m_ovf | o;
                m_run = 0;
                m_cnt = 0;
                m_ovf = 1'b0;
            end else begin
                m_run = t;
                m_ovf = m_ovf | o;
                m_cnt++;
            end
        end
        if (fin) begin
            if (!m_sv || a_ready) begin
                m_sv   = 1'b1;
                m_sum  = res;
                m_sovf = rovf;
            end else begin
                m_drop = 1'b1;
            end
        end else if (m_sv && a_ready) begin
            m_sv = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (model_on) model_step();
        #1;
    endtask

    task automatic beat(input int v);
        a_mac_valid = 1'b1;
        a_mac_in    = 8'(v);
        tick();
        a_mac_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_sum_out"}, int'(a_sum_out), 0);
        check({tag, "_sum_valid"}, int'(a_sum_valid), 0);
        check({tag, "_sum_overflow"}, int'(a_sum_overflow), 0);
        check({tag, "_drop_err"}, int'(a_drop_err), 0);
        check({tag, "_beat_count"}, int'(a_beat_count), 0);
    endtask

    initial begin
        tbl[0] = '{a: 100,  b: 100,  exp_sum: SAT ? 127 : -56,   exp_ovf: 1};
        tbl[1] = '{a: -100, b: -100, exp_sum: SAT ? -128 : 56,   exp_ovf: 1};
        tbl[2] = '{a: 1,    b: 2,    exp_sum: 3,                 exp_ovf: 0};
        tbl[3] = '{a: 127,  b: 1,    exp_sum: SAT ? 127 : -128,  exp_ovf: 1};
        tbl[4] = '{a: -128, b: -1,   exp_sum: SAT ? -128 : 127,  exp_ovf: 1};
        tbl[5] = '{a: -128, b: 127,  exp_sum: -1,                exp_ovf: 0};
        tbl[6] = '{a: -50,  b: 20,   exp_sum: -30,               exp_ovf: 0};

        tests = 0;
        fails = 0;
        model_on = 1'b0;
        reset_n = 1'b0;
        a_mac_in = '0; a_mac_valid = 1'b0; a_clear = 1'b0; a_ready = 1'b0;
        b_mac_in = '0; b_mac_valid = 1'b0; b_clear = 1'b0; b_ready = 1'b1;
        #12;
        check_a_zero("reset");
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Back-to-back vector, output always accepted.
        a_ready = 1'b1;
        beat(3); beat(-5); beat(10); beat(7);
        check("b2b_sum", int'(a_sum_out), 15);
        check("b2b_valid", int'(a_sum_valid), 1);
        check("b2b_ovf", int'(a_sum_overflow), 0);
        check("b2b_count", int'(a_beat_count), 0);
        tick();
        check("b2b_valid_drop", int'(a_sum_valid), 0);

        // Gapped beats, result held under backpressure.
        a_ready = 1'b0;
        beat(3); idle(2); beat(-5); idle(1); beat(10); idle(3); beat(7);
        check("gap_sum", int'(a_sum_out), 15);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_sum", int'(a_sum_out), 15);
            check("hold_valid", int'(a_sum_valid), 1);
        end
        a_ready = 1'b1;
        tick();
        check("accept_valid", int'(a_sum_valid), 0);

        // Second result collides with an unaccepted first one.
        a_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(1);
        for (int i = 0; i < 4; i++) beat(2);
        check("drop_sum", int'(a_sum_out), 4);
        check("drop_valid", int'(a_sum_valid), 1);
        check("drop_err", int'(a_drop_err), 1);
        a_clear = 1'b1;
        tick();
        a_clear = 1'b0;
        check("clear_drop_err", int'(a_drop_err), 0);
        check("clear_keeps_valid", int'(a_sum_valid), 1);
        check("clear_keeps_sum", int'(a_sum_out), 4);
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        check("drain_valid", int'(a_sum_valid), 0);

        // Same collision, but accepted on the completion cycle.
        for (int i = 0; i < 4; i++) beat(1);
        for (int i = 0; i < 3; i++) beat(2);
        a_ready = 1'b1;
        beat(2);
        check("reload_sum", int'(a_sum_out), 8);
        check("reload_valid", int'(a_sum_valid), 1);
        check("reload_drop", int'(a_drop_err), 0);
        tick();
        check("reload_drain", int'(a_sum_valid), 0);

        // Clear coincident with a beat discards it.
        beat(5); beat(5);
        check("pre_clear_count", int'(a_beat_count), 2);
        a_clear = 1'b1; a_mac_valid = 1'b1; a_mac_in = 8'd9;
        tick();
        a_clear = 1'b0; a_mac_valid = 1'b0;
        check("clear_count", int'(a_beat_count), 0);
        for (int i = 0; i < 4; i++) beat(1);
        check("post_clear_sum", int'(a_sum_out), 4);
        check("post_clear_valid", int'(a_sum_valid), 1);
        tick();

        // Asynchronous reset mid-vector with a result held.
        a_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(3);
        check("pre_reset_sum", int'(a_sum_out), 12);
        beat(1); beat(1);
        check("pre_reset_count", int'(a_beat_count), 2);
        #3;
        reset_n = 1'b0;
        #1;
        check_a_zero("async_reset");
        reset_n = 1'b1;
        a_ready = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) beat(2);
        check("post_reset_sum", int'(a_sum_out), 8);
        check("post_reset_valid", int'(a_sum_valid), 1);
        tick();

        // Narrow accumulator overflow table.
        for (int i = 0; i < 7; i++) begin
            b_mac_valid = 1'b1;
            b_mac_in = 8'(tbl[i].a);
            tick();
            b_mac_in = 8'(tbl[i].b);
            tick();
            b_mac_valid = 1'b0;
            check($sformatf("tbl%0d_sum", i), int'(b_sum_out), tbl[i].exp_sum);
            check($sformatf("tbl%0d_ovf", i), int'(b_sum_overflow), tbl[i].exp_ovf);
            check($sformatf("tbl%0d_valid", i), int'(b_sum_valid), 1);
            check($sformatf("tbl%0d_count", i), int'(b_beat_count), 0);
            check($sformatf("tbl%0d_drop", i), int'(b_drop_err), 0);
        end

        // Randomized run against the reference model.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        m_run = 0; m_cnt = 0; m_ovf = 1'b0; m_sv = 1'b0; m_sum = 0; m_sovf = 1'b0; m_drop = 1'b0;
        model_on = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            a_mac_valid = ($urandom_range(0, 9) < 7);
            a_mac_in    = 8'($urandom);
            a_clear     = ($urandom_range(0, 39) == 0);
            a_ready     = ($urandom_range(0, 1) == 1);
            tick();
            check("rnd_valid", int'(a_sum_valid), int'(m_sv));
            check("rnd_drop", int'(a_drop_err), int'(m_drop));
            check("rnd_count", int'(a_beat_count), m_cnt);
            if (m_sv) begin
                check("rnd_sum", int'(a_sum_out), m_sum);
                check("rnd_ovf", int'(a_sum_overflow), int'(m_sovf));
            end
        end
        model_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dot_product_accumulator.md
Name: dot_product_accumulator

Overview:
- Downstream consumer of the pipelined multiply-accumulate stage.
- Takes the MAC result stream (`mac_out`/`valid_out`) and sums VECTOR_LEN consecutive valid products into one dot-product result.
- Presents each finished result on a valid/ready output register.
- Upstream has no backpressure, so accumulation continues while a result waits; collisions are flagged, never stalled.

Parameters:
- IN_WIDTH, 64, width of the signed MAC result input.
- ACC_WIDTH, 64, width of the accumulator and output. Must be >= IN_WIDTH.
- VECTOR_LEN, 8, number of valid products per result. Must be >= 1.
- CNT_WIDTH, $clog2(VECTOR_LEN+1), beat counter width.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mac_in  in  IN_WIDTH  signed product/sum from the MAC stage.
- mac_valid  in  1  mac_in valid this cycle.
- clear  in  1  synchronous abort of the partial vector.
- sum_out  out  ACC_WIDTH  signed dot-product result.
- sum_overflow  out  1  result overflowed (wrapped, or clamped if saturating).
- sum_valid  out  1  result available.
- sum_ready  in  1  consumer accepts the result.
- drop_err  out  1  sticky: a finished result was discarded.
- beat_count  out  CNT_WIDTH  beats accumulated in the current vector.

Behaviour:
- Reset (async assert): acc=0, beat_count=0, sum_out=0, sum_overflow=0, sum_valid=0, drop_err=0, internal overflow flag=0.
- Reset deassertion is used synchronously to clock.
- Accumulate, on mac_valid=1 and clear=0:
  - next = acc + sign_extend(mac_in, ACC_WIDTH).
  - Overflow when both operands have the same sign and next differs from it; ORs into an internal sticky flag.
- Beat with beat_count < VECTOR_LEN-1: acc <= next; beat_count increments.
- Last beat (beat_count == VECTOR_LEN-1):
  - Result is next; result overflow is flag OR this beat's overflow.
  - acc <= 0, beat_count <= 0, internal flag <= 0.
- Result load: result goes to sum_out/sum_overflow and sum_valid <= 1 when the output is empty, or when sum_valid & sum_ready in the same cycle.
- Result drop: if sum_valid=1 and sum_ready=0, the result is discarded; drop_err <= 1; the held output is unchanged.
- Latency: last beat at edge N gives sum_valid=1 after edge N (visible in cycle N+1).
- Throughput: one beat per cycle. With VECTOR_LEN=1, one result per cycle when sum_ready is held high.
- Handshake:
  - Transfer occurs on sum_valid & sum_ready at a rising edge.
  - sum_out and sum_overflow are stable while sum_valid=1 and not accepted.
  - sum_valid drops after acceptance unless a reload happens the same cycle.
- clear=1: acc, beat_count and internal flag go to 0; any same-cycle mac beat is discarded (clear wins); drop_err is cleared. Output register and sum_valid are unaffected.
- mac_valid=0: no state change except the output handshake.
- sum_ready while sum_valid=0: ignored.
- Reset mid-vector: the partial sum is lost; the first beat after reset starts a new vector.

Optional Feature:
- Macro: DOT_PRODUCT_ACC_SATURATE_EN.
- Defined:
  - On overflow, next clamps to the max positive value (2^(ACC_WIDTH-1)-1) or min negative value (-2^(ACC_WIDTH-1)), following the operand sign.
  - Further beats continue from the clamped value; sum_overflow still reports it.
- Undefined: two's-complement wrap; sum_overflow reports wrap. No saturation logic is synthesised.

Test Plan:
- VECTOR_LEN=4, beats 3, -5, 10, 7 back-to-back, sum_ready=1 -> one cycle after beat 4: sum_out=15, sum_valid=1 for one cycle, sum_overflow=0, beat_count returns to 0.
- Beats gapped by mac_valid=0 cycles, sum_ready=0 for 5 cycles after the result -> sum_out=15 held stable; sum_valid falls the cycle after sum_ready=1.
- Two vectors, first result unaccepted when the second completes -> sum_out keeps the first value and drop_err=1. Same again but sum_ready=1 on the completion cycle -> second value loaded, sum_valid stays 1, drop_err=0.
- ACC_WIDTH=IN_WIDTH=8, VECTOR_LEN=2, beats 100, 100:
  - Without macro: sum_out=-56, sum_overflow=1.
  - With DOT_PRODUCT_ACC_SATURATE_EN: sum_out=127, sum_overflow=1.
- Two beats accumulated, then clear=1 coincident with a mac beat -> beat_count=0; the next 4 beats of 1 give sum_out=4.
- reset_n pulsed low asynchronously mid-vector and while sum_valid=1 -> all outputs 0 immediately; a fresh vector of 2, 2, 2, 2 gives 8.
